fifo_8deep: RTL and testbench

FIFO_8DEEP -- requirements
Module: fifo_8deep

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_8deep_if.sv | 30 +++
 rtl/dff.sv | 19 +
 rtl/fifo_ptr.sv | 32 +++
 rtl/fifo_8deep.sv | 98 +++++++++
 tb/tb_fifo_8deep.sv | 173 +++++++++++++++++
 6 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing constants for the 8-deep FIFO and its pointer sub-module.
package fifo_pkg;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned PTR_W    = 3;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned AF_LEVEL = 7;
  localparam int unsigned AE_LEVEL = 1;

endpackage

// File: rtl/fifo_8deep_if.sv
// Request/status bundle between a FIFO user (master) and fifo_8deep (slave).
interface fifo_8deep_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) ();

  logic              clr;
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              almost_full;
  logic              almost_empty;
  logic              err;

  modport master (
    output clr, push, data_in, pop,
    input  data_out, full, empty, count, almost_full, almost_empty, err
  );

  modport slave (
    input  clr, push, data_in, pop,
    output data_out, full, empty, count, almost_full, almost_empty, err
  );

endinterface

// File: rtl/dff.sv
// Plain D flip-flop bank with synchronous active-high reset to zero.
module dff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: clr beats inc; the natural 3-bit overflow provides the 7 -> 0 wrap.
module fifo_ptr
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr + 1'b1;
    end
  end

  dff #(
    .W (PTR_W)
  ) u_dff (
    .clk (clk),
    .rst (rst),
    .d   (ptr_d),
    .q   (ptr)
  );

endmodule

// File: rtl/fifo_8deep.sv
// 8-entry first-word-fall-through FIFO with registered status and error pulse.
// Define FIFO_ALMOST_FLAGS_EN to build the almost_full / almost_empty flags.
module fifo_8deep
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  fifo_8deep_if.slave  bus
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d, err_q, err_d;
  logic              push_ok, pop_ok;

  // A pop on a full FIFO frees the slot, so the simultaneous push is accepted too.
  always_comb begin
    pop_ok  = bus.pop & ~empty_q;
    push_ok = bus.push & (~full_q | pop_ok);
    count_d = count_q;
    err_d   = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      err_d   = (bus.push & ~push_ok) | (bus.pop & ~pop_ok);
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  fifo_ptr u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_ok),
    .clr (bus.clr),
    .ptr (wr_ptr)
  );

  fifo_ptr u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_ok),
    .clr (bus.clr),
    .ptr (rd_ptr)
  );

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok && !bus.clr && !rst) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  assign bus.data_out = empty_q ? '0 : mem[rd_ptr];
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.err      = err_q;

`ifdef FIFO_ALMOST_FLAGS_EN
  logic af_q, ae_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= (count_d >= CNT_W'(AF_LEVEL));
      ae_q <= (count_d <= CNT_W'(AE_LEVEL));
    end
  end

  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
`else
  assign bus.almost_full  = 1'b0;
  assign bus.almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_8deep.sv
// Bench for fifo_8deep: queue-based reference model checked every cycle plus directed literals.
module tb_fifo_8deep;

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam bit ALMOST_EN = 1'b1;
`else
  localparam bit ALMOST_EN = 1'b0;
`endif
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_8deep_if #(.DATA_W(DW)) bus ();

  fifo_8deep #(
    .DATA_W (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted words and the expected error pulse.
  logic [DW-1:0] q [$];
  bit m_err = 1'b0;
  bit m_ok  = 1'b0;

  always @(posedge clk) begin
    bit po, pu;
    if (rst) begin
      q.delete();
      m_err = 1'b0;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      if (bus.clr) begin
        q.delete();
        m_err = 1'b0;
      end else begin
        po    = bus.pop && (q.size() != 0);
        pu    = bus.push && ((q.size() < 8) || po);
        m_err = (bus.push && !pu) || (bus.pop && !po);
        if (po) void'(q.pop_front());
        if (pu) q.push_back(bus.data_in);
      end
    end
  end

  always @(negedge clk) begin
    int n;
    if (m_ok) begin
      n = q.size();
      chk("m_count", 32'(bus.count), n);
      chk("m_full", 32'(bus.full), 32'(n == 8));
      chk("m_empty", 32'(bus.empty), 32'(n == 0));
      chk("m_err", 32'(bus.err), 32'(m_err));
      chk("m_data_out", 32'(bus.data_out), (n != 0) ? 32'(q[0]) : 32'h0);
      chk("m_almost_full", 32'(bus.almost_full), 32'(ALMOST_EN && (n >= 7)));
      chk("m_almost_empty", 32'(bus.almost_empty), 32'(ALMOST_EN && (n <= 1)));
    end
  end

  task automatic step(input bit r, input bit c, input bit pu, input bit po,
                      input logic [DW-1:0] d);
    rst         = r;
    bus.clr     = c;
    bus.push    = pu;
    bus.pop     = po;
    bus.data_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 32'h0);
    chk({tag, "_empty"}, 32'(bus.empty), 32'h1);
    chk({tag, "_full"}, 32'(bus.full), 32'h0);
    chk({tag, "_err"}, 32'(bus.err), 32'h0);
    chk({tag, "_data_out"}, 32'(bus.data_out), 32'h0);
    chk({tag, "_almost_empty"}, 32'(bus.almost_empty), 32'(ALMOST_EN));
    chk({tag, "_almost_full"}, 32'(bus.almost_full), 32'h0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.clr     = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    chk_reset_vals("reset");

    // Fill 0x0001..0x0008; almost_full rises on 6 -> 7.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'(i));
      if (i == 6) chk("af_at_6", 32'(bus.almost_full), 32'h0);
      if (i == 7) chk("af_at_7", 32'(bus.almost_full), 32'(ALMOST_EN));
    end
    chk("fill_full", 32'(bus.full), 32'h1);
    chk("fill_count", 32'(bus.count), 32'h8);
    chk("fill_head", 32'(bus.data_out), 32'h0001);
    chk("fill_err", 32'(bus.err), 32'h0);

    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h00AA);
    chk("ovf_err", 32'(bus.err), 32'h1);
    chk("ovf_count", 32'(bus.count), 32'h8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("ovf_err_drop", 32'(bus.err), 32'h0);

    // Drain in order; almost_empty rises on 2 -> 1.
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", 32'(bus.data_out), 32'(i));
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      if (i == 6) chk("ae_at_2", 32'(bus.almost_empty), 32'h0);
      if (i == 7) chk("ae_at_1", 32'(bus.almost_empty), 32'(ALMOST_EN));
    end
    chk("drain_empty", 32'(bus.empty), 32'h1);
    chk("drain_data_out", 32'(bus.data_out), 32'h0);

    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
    chk("udf_err", 32'(bus.err), 32'h1);
    chk("udf_count", 32'(bus.count), 32'h1);
    chk("udf_data", 32'(bus.data_out), 32'h1234);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);

    // Full-rate push+pop while full; pointers wrap past 7.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 16'(32'h100 + i));
    for (int j = 0; j < 12; j++) begin
      chk("stream_head", 32'(bus.data_out), (j < 8) ? 32'(32'h100 + j) : 32'(32'h200 + j - 8));
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'(32'h200 + j));
      chk("stream_count", 32'(bus.count), 32'h8);
      chk("stream_err", 32'(bus.err), 32'h0);
    end

    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 16'(32'h300 + i));
    chk("pre_clr_count", 32'(bus.count), 32'h5);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    chk("clr_count", 32'(bus.count), 32'h0);
    chk("clr_empty", 32'(bus.empty), 32'h1);
    chk("clr_err", 32'(bus.err), 32'h0);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 16'(32'h400 + i));
    chk("pre_rst_count", 32'(bus.count), 32'h3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'hDEAD);
    chk_reset_vals("mid_rst");

    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0055);
    chk("post_rst_head", 32'(bus.data_out), 32'h0055);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    chk("empty_pop_err", 32'(bus.err), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("empty_pop_err_drop", 32'(bus.err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
